decode_ctrl_pipe: RTL and testbench
===================================

# decode_ctrl_pipe

Registered, parametrised instruction-decode stage for the vector core, placed between the fetch register and execute. It decodes the 32-bit big-endian-ordered instruction word into register addresses and control enables, holds them in a pipeline register with a valid/ready handshake, and stalls fetch on read-after-write hazards against a scoreboard of in-flight writes. It also supports branch flush, an addressing-mode parameter, and an illegal-instruction flag with a saturating error counter.

## Interface
- INST_W, 32: instruction width; field map fixed in bits [0:31], extra MSB-side bits ignored.
- RADDR_W, 5: register address width; must be 5 for the current field map.
- WB_DEPTH, 3: scoreboard entries (ID register plus in-flight writer stages before register-file write), 1..8.
- ADDR_MODE, 0: 0 = absolute-only memory/branch (rA must be 0, else illegal); 1 = base+offset (any rA, rA becomes a source).
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_valid  in  1  fetch presents an instruction.
- if_inst  in  [0:INST_W-1]  instruction word.
- id_stall  out  1  combinational; fetch must hold if_inst when 1.
- ex_ready  in  1  execute accepts the ID register this cycle.
- flush  in  1  taken branch; kill instruction in ID and at input.
- id_valid  out  1  ID register holds an instruction.
- id_rD, id_rA, id_rB  out  RADDR_W each  inst[6:10], [11:15], [16:20].
- id_ppp  out  3  inst[21:23].
- id_WW  out  2  inst[24:25].
- id_opcode  out  6  inst[26:31].
- id_imm  out  16  inst[16:31].
- id_wrEn, id_memEn, id_memwrEn, id_bez, id_bnez  out  1 each  control enables.
- id_illegal  out  1  instruction in ID is illegal.
- err_cnt  out  8  saturating count of illegal instructions issued.

## Operation
- Type field inst[0:5]: RTYPE 101010, VLD 100000, VSD 100001, VBEZ 100010, VBNEZ 100011, VNOP 111100.
- Enables per type: RTYPE wrEn; VLD memEn+wrEn; VSD memEn+memwrEn; VBEZ bez; VBNEZ bnez; VNOP none.
- ADDR_MODE=0 and rA≠0 on VLD/VSD/VBEZ/VBNEZ → illegal. Unknown type → illegal. Illegal: all enables 0, id_illegal=1, id_valid=1.
- Sources: RTYPE rA,rB; VSD rD (+rA if ADDR_MODE=1); VBEZ/VBNEZ rD (+rA if ADDR_MODE=1); VLD rA if ADDR_MODE=1; VNOP/illegal none.
- Scoreboard SB[0..WB_DEPTH-1] of {v, rD}; SB[0] mirrors the ID register (v = id_valid & id_wrEn).
- hazard = any source equal to rD of any SB entry with v=1.
- advance = ex_ready | ~id_valid.
- id_stall = if_valid & ~flush & (hazard | ~advance).
- On advance: SB shifts toward older (SB[WB_DEPTH-1] dropped); ID register and SB[0] load the new instruction if if_valid & ~hazard & ~flush, else a bubble (id_valid=0, SB[0].v=0).
- No advance: ID register and SB hold; if_inst is not consumed.
- flush: ID register and SB[0] cleared to a bubble the same edge, regardless of ex_ready; the input instruction is discarded; SB[1..] still shift if advance, else hold.
- err_cnt increments when an illegal instruction loads into ID; saturates at 255.

## Timing
- Reset (async assert, sync release): id_valid, all enables, id_illegal, every field output, SB and err_cnt = 0; id_stall = 0.
- Latency: if_inst accepted at edge N appears on ID outputs after edge N, one cycle.
- Hazard stall lasts until the matching entry shifts out of SB: at most WB_DEPTH cycles when ex_ready=1 continuously.
- Field outputs are don't-care when id_valid=0, but they must still be 0 after reset.
- Back-to-back independent instructions issue every cycle.
- Simultaneous flush and hazard: flush wins and id_stall=0.

## Test plan
- Reset mid-stream: with id_valid=1, assert reset_n=0 → all outputs 0 immediately; err_cnt=0.
- RTYPE rD=3 then RTYPE rA=3 with WB_DEPTH=3 and ex_ready=1 → 3 stall cycles with id_valid=0 bubbles, then issue; an independent RTYPE rA=4 issues without stall.
- VBNEZ rD=1, rA=0 → id_bnez=1, id_bez=0; VBEZ → id_bez=1 only; VSD → memEn=memwrEn=1 and wrEn=0.
- ADDR_MODE=0, VLD with rA=2 → id_illegal=1, all enables 0, err_cnt +1; the same instruction under ADDR_MODE=1 → memEn=wrEn=1 and no illegal flag.
- ex_ready=0 for 4 cycles with id_valid=1 → ID outputs stable, id_stall=1 while if_valid=1; release → next instruction issues one cycle later.
- flush while ID holds an RTYPE writer of rD=5 and the input reads r5 → id_valid=0 next cycle, input dropped; a subsequent reader of r5 issues without stall; 300 illegal instructions → err_cnt=255.

Source files
------------

// File: rtl/decode_ctrl_pipe.sv
// Instruction-decode pipeline stage: field/enable decode, valid/ready ID register,
// RAW-hazard scoreboard of in-flight writers, branch flush and illegal-op counting.
module decode_ctrl_pipe #(
  parameter int          INST_W    = 32,
  parameter int          RADDR_W   = 5,
  parameter int unsigned WB_DEPTH  = 3,
  parameter int          ADDR_MODE = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               if_valid,
  input  logic [0:INST_W-1]  if_inst,
  output logic               id_stall,
  input  logic               ex_ready,
  input  logic               flush,
  output logic               id_valid,
  output logic [RADDR_W-1:0] id_rD,
  output logic [RADDR_W-1:0] id_rA,
  output logic [RADDR_W-1:0] id_rB,
  output logic [2:0]         id_ppp,
  output logic [1:0]         id_WW,
  output logic [5:0]         id_opcode,
  output logic [15:0]        id_imm,
  output logic               id_wrEn,
  output logic               id_memEn,
  output logic               id_memwrEn,
  output logic               id_bez,
  output logic               id_bnez,
  output logic               id_illegal,
  output logic [7:0]         err_cnt
);

  typedef enum logic [5:0] {
    T_VLD   = 6'b100000,
    T_VSD   = 6'b100001,
    T_VBEZ  = 6'b100010,
    T_VBNEZ = 6'b100011,
    T_RTYPE = 6'b101010,
    T_VNOP  = 6'b111100
  } inst_type_e;

  // Field map occupies the 32 LSB-side bits; any extra MSB-side bits are ignored.
  localparam int B = INST_W - 32;

  logic [5:0]         f_typ;
  logic [RADDR_W-1:0] f_rd, f_ra, f_rb;
  logic [2:0]         f_ppp;
  logic [1:0]         f_ww;
  logic [5:0]         f_op;
  logic [15:0]        f_imm;

  assign f_typ = if_inst[B      +: 6];
  assign f_rd  = if_inst[B + 6  +: RADDR_W];
  assign f_ra  = if_inst[B + 11 +: RADDR_W];
  assign f_rb  = if_inst[B + 16 +: RADDR_W];
  assign f_ppp = if_inst[B + 21 +: 3];
  assign f_ww  = if_inst[B + 24 +: 2];
  assign f_op  = if_inst[B + 26 +: 6];
  assign f_imm = if_inst[B + 16 +: 16];

  logic d_wr, d_mem, d_memwr, d_bez, d_bnez, d_ill;
  logic use_d, use_a, use_b, ra_bad;

  always_comb begin
    d_wr    = 1'b0;
    d_mem   = 1'b0;
    d_memwr = 1'b0;
    d_bez   = 1'b0;
    d_bnez  = 1'b0;
    d_ill   = 1'b0;
    use_d   = 1'b0;
    use_a   = 1'b0;
    use_b   = 1'b0;
    ra_bad  = (ADDR_MODE == 0) && (f_ra != '0);
    case (f_typ)
      T_RTYPE: begin
        d_wr  = 1'b1;
        use_a = 1'b1;
        use_b = 1'b1;
      end
      T_VLD: begin
        if (ra_bad) d_ill = 1'b1;
        else begin
          d_mem = 1'b1;
          d_wr  = 1'b1;
          use_a = (ADDR_MODE != 0);
        end
      end
      T_VSD: begin
        if (ra_bad) d_ill = 1'b1;
        else begin
          d_mem   = 1'b1;
          d_memwr = 1'b1;
          use_d   = 1'b1;
          use_a   = (ADDR_MODE != 0);
        end
      end
      T_VBEZ, T_VBNEZ: begin
        if (ra_bad) d_ill = 1'b1;
        else begin
          d_bez  = (f_typ == T_VBEZ);
          d_bnez = (f_typ == T_VBNEZ);
          use_d  = 1'b1;
          use_a  = (ADDR_MODE != 0);
        end
      end
      T_VNOP:  ;
      default: d_ill = 1'b1;
    endcase
  end

  // Scoreboard: entry 0 tracks the ID register, higher entries are older writers.
  logic               sb_v  [WB_DEPTH];
  logic [RADDR_W-1:0] sb_rd [WB_DEPTH];
  logic               hazard, advance, load;

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      if (sb_v[i] && ((use_d && f_rd == sb_rd[i]) ||
                      (use_a && f_ra == sb_rd[i]) ||
                      (use_b && f_rb == sb_rd[i])))
        hazard = 1'b1;
    end
  end

  assign advance  = ex_ready | ~id_valid;
  assign load     = if_valid & ~hazard;
  assign id_stall = if_valid & ~flush & (hazard | ~advance);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_valid   <= 1'b0;
      id_rD      <= '0;
      id_rA      <= '0;
      id_rB      <= '0;
      id_ppp     <= '0;
      id_WW      <= '0;
      id_opcode  <= '0;
      id_imm     <= '0;
      id_wrEn    <= 1'b0;
      id_memEn   <= 1'b0;
      id_memwrEn <= 1'b0;
      id_bez     <= 1'b0;
      id_bnez    <= 1'b0;
      id_illegal <= 1'b0;
      err_cnt    <= '0;
      for (int unsigned i = 0; i < WB_DEPTH; i++) begin
        sb_v[i]  <= 1'b0;
        sb_rd[i] <= '0;
      end
    end else begin
      if (advance) begin
        for (int unsigned i = 1; i < WB_DEPTH; i++) begin
          sb_v[i]  <= sb_v[i-1];
          sb_rd[i] <= sb_rd[i-1];
        end
      end
      if (flush || (advance && !load)) begin
        id_valid   <= 1'b0;
        id_wrEn    <= 1'b0;
        id_memEn   <= 1'b0;
        id_memwrEn <= 1'b0;
        id_bez     <= 1'b0;
        id_bnez    <= 1'b0;
        id_illegal <= 1'b0;
        sb_v[0]    <= 1'b0;
      end else if (advance) begin
        id_valid   <= 1'b1;
        id_rD      <= f_rd;
        id_rA      <= f_ra;
        id_rB      <= f_rb;
        id_ppp     <= f_ppp;
        id_WW      <= f_ww;
        id_opcode  <= f_op;
        id_imm     <= f_imm;
        id_wrEn    <= d_wr;
        id_memEn   <= d_mem;
        id_memwrEn <= d_memwr;
        id_bez     <= d_bez;
        id_bnez    <= d_bnez;
        id_illegal <= d_ill;
        sb_v[0]    <= d_wr;
        sb_rd[0]   <= f_rd;
        if (d_ill && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations (second instance in base+offset mode).
module tb_decode_ctrl_pipe;

  localparam int D = 3;
  localparam logic [5:0] RT = 6'b101010, VLD = 6'b100000, VSD = 6'b100001,
                         VBEZ = 6'b100010, VBNEZ = 6'b100011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, if_valid, ex_ready, flush;
  logic [0:31] if_inst;
  logic        id_stall, id_valid, id_wrEn, id_memEn, id_memwrEn, id_bez, id_bnez, id_illegal;
  logic [4:0]  id_rD, id_rA, id_rB;
  logic [2:0]  id_ppp;
  logic [1:0]  id_WW;
  logic [5:0]  id_opcode;
  logic [15:0] id_imm;
  logic [7:0]  err_cnt;

  logic        a1_valid, a1_ready, a1_flush;
  logic [0:31] a1_inst;
  logic        a1_stall, a1_vld, a1_wr, a1_mem, a1_memwr, a1_bez, a1_bnez, a1_ill;
  logic [4:0]  a1_rD, a1_rA, a1_rB;
  logic [2:0]  a1_ppp;
  logic [1:0]  a1_WW;
  logic [5:0]  a1_op;
  logic [15:0] a1_imm;
  logic [7:0]  a1_err;

  decode_ctrl_pipe #(.INST_W(32), .RADDR_W(5), .WB_DEPTH(D), .ADDR_MODE(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_inst(if_inst),
    .id_stall(id_stall), .ex_ready(ex_ready), .flush(flush), .id_valid(id_valid),
    .id_rD(id_rD), .id_rA(id_rA), .id_rB(id_rB), .id_ppp(id_ppp), .id_WW(id_WW),
    .id_opcode(id_opcode), .id_imm(id_imm), .id_wrEn(id_wrEn), .id_memEn(id_memEn),
    .id_memwrEn(id_memwrEn), .id_bez(id_bez), .id_bnez(id_bnez),
    .id_illegal(id_illegal), .err_cnt(err_cnt));

  decode_ctrl_pipe #(.INST_W(32), .RADDR_W(5), .WB_DEPTH(D), .ADDR_MODE(1)) u_am1 (
    .clk(clk), .reset_n(reset_n), .if_valid(a1_valid), .if_inst(a1_inst),
    .id_stall(a1_stall), .ex_ready(a1_ready), .flush(a1_flush), .id_valid(a1_vld),
    .id_rD(a1_rD), .id_rA(a1_rA), .id_rB(a1_rB), .id_ppp(a1_ppp), .id_WW(a1_WW),
    .id_opcode(a1_op), .id_imm(a1_imm), .id_wrEn(a1_wr), .id_memEn(a1_mem),
    .id_memwrEn(a1_memwr), .id_bez(a1_bez), .id_bnez(a1_bnez),
    .id_illegal(a1_ill), .err_cnt(a1_err));

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] t, input logic [4:0] rd,
                                     input logic [4:0] ra, input logic [4:0] rb);
    return {t, rd, ra, rb, 11'b101_10_110011};
  endfunction

  // ---------------- reference model (absolute addressing, depth D) ----------------
  typedef struct { logic [4:0] rd; int pos; } wr_t;
  wr_t         wq[$];
  logic        m_valid, m_ill;
  logic [31:0] m_w;
  logic [4:0]  m_en;   // {wr, mem, memwr, bez, bnez}
  int          m_err;

  // src = {reads rD, reads rA, reads rB}
  function automatic void dec(input logic [31:0] w, output logic [4:0] en,
                              output logic ill, output logic [2:0] src);
    logic bad;
    bad = (w[20:16] != 5'd0);
    en = '0; ill = 1'b0; src = '0;
    case (w[31:26])
      RT:      begin en = 5'b10000; src = 3'b011; end
      VLD:     if (bad) ill = 1'b1; else en = 5'b11000;
      VSD:     if (bad) ill = 1'b1; else begin en = 5'b01100; src = 3'b100; end
      VBEZ:    if (bad) ill = 1'b1; else begin en = 5'b00010; src = 3'b100; end
      VBNEZ:   if (bad) ill = 1'b1; else begin en = 5'b00001; src = 3'b100; end
      6'b111100: ;
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic hz(input logic [31:0] w);
    logic [4:0] en; logic ill; logic [2:0] src;
    dec(w, en, ill, src);
    foreach (wq[i])
      if ((src[2] && wq[i].rd == w[25:21]) || (src[1] && wq[i].rd == w[20:16]) ||
          (src[0] && wq[i].rd == w[15:11]))
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic drop_where(input int min_pos, input int max_pos);
    for (int i = wq.size() - 1; i >= 0; i--)
      if (wq[i].pos >= min_pos && wq[i].pos <= max_pos) wq.delete(i);
  endtask

  task automatic age();
    foreach (wq[i]) wq[i].pos++;
    drop_where(D, 1000);
  endtask

  always @(posedge clk or negedge reset_n) begin : model
    logic [31:0] w; logic h, adv, ill; logic [4:0] en; logic [2:0] src;
    if (!reset_n) begin
      m_valid = 1'b0; m_w = '0; m_en = '0; m_ill = 1'b0; m_err = 0;
      wq.delete();
    end else begin
      w = if_inst;
      h = hz(w);
      adv = ex_ready || !m_valid;
      if (flush) begin
        if (adv) age(); else drop_where(0, 0);
        m_valid = 1'b0; m_en = '0; m_ill = 1'b0;
      end else if (adv) begin
        age();
        if (if_valid && !h) begin
          dec(w, en, ill, src);
          m_valid = 1'b1; m_w = w; m_en = en; m_ill = ill;
          if (en[4]) wq.push_back('{w[25:21], 0});
          if (ill && m_err < 255) m_err++;
        end else begin
          m_valid = 1'b0; m_en = '0; m_ill = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic exp_stall;
    exp_stall = if_valid && !flush && (hz(if_inst) || !(ex_ready || !m_valid));
    chk("m_valid", id_valid, m_valid);
    chk("m_enables", {id_wrEn, id_memEn, id_memwrEn, id_bez, id_bnez}, m_en);
    chk("m_illegal", id_illegal, m_ill);
    chk("m_err_cnt", err_cnt, m_err);
    chk("m_stall", id_stall, exp_stall);
    if (m_valid) begin
      chk("m_fields", {id_rD, id_rA, id_rB, id_ppp, id_WW, id_opcode}, m_w[25:0]);
      chk("m_imm", id_imm, m_w[15:0]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input logic [31:0] w, output int stalls);
    if_valid = 1'b1; if_inst = w; flush = 1'b0; ex_ready = 1'b1; stalls = 0;
    forever begin
      @(negedge clk);
      if (!id_stall) break;
      stalls++;
      if (stalls > 40) begin
        checks++; failures++;
        $display("FAIL send_timeout: stalled %0d cycles, expected at most %0d", stalls, D);
        break;
      end
      @(posedge clk);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int s;
    reset_n = 1'b0; if_valid = 1'b1; if_inst = mk(RT, 3, 1, 2); flush = 1'b0; ex_ready = 1'b1;
    a1_valid = 1'b0; a1_inst = '0; a1_ready = 1'b1; a1_flush = 1'b0;
    #2;
    chk("rst_valid", id_valid, 0);
    chk("rst_fields", {id_rD, id_rA, id_rB, id_ppp, id_WW, id_opcode, id_imm}, 0);
    chk("rst_enables", {id_wrEn, id_memEn, id_memwrEn, id_bez, id_bnez, id_illegal}, 0);
    chk("rst_stall", id_stall, 0);
    chk("rst_err", err_cnt, 0);
    if_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // RAW hazard: reader of r3 waits for the writer to leave the scoreboard
    send(mk(RT, 3, 1, 2), s);
    chk("wr_issue", {id_valid, id_wrEn, id_rD}, {1'b1, 1'b1, 5'd3});
    send(mk(RT, 6, 3, 4), s);
    chk("raw_stalls", s, 3);
    chk("raw_issue_rA", id_rA, 3);
    send(mk(RT, 7, 4, 0), s);
    chk("indep_stalls", s, 0);

    send(mk(VBNEZ, 1, 0, 0), s);
    chk("vbnez_en", {id_wrEn, id_memEn, id_memwrEn, id_bez, id_bnez}, 5'b00001);
    send(mk(VBEZ, 1, 0, 0), s);
    chk("vbez_en", {id_wrEn, id_memEn, id_memwrEn, id_bez, id_bnez}, 5'b00010);
    send(mk(VSD, 2, 0, 0), s);
    chk("vsd_en", {id_wrEn, id_memEn, id_memwrEn}, 3'b011);

    // absolute mode rejects a nonzero base; base+offset mode accepts it
    send(mk(VLD, 9, 2, 0), s);
    chk("vld_abs_illegal", {id_valid, id_illegal}, 2'b11);
    chk("vld_abs_enables", {id_wrEn, id_memEn, id_memwrEn, id_bez, id_bnez}, 0);
    chk("vld_abs_err", err_cnt, 1);
    a1_valid = 1'b1; a1_inst = mk(VLD, 9, 2, 0);
    @(posedge clk); #1;
    a1_valid = 1'b0;
    chk("vld_bo_valid", a1_vld, 1);
    chk("vld_bo_en", {a1_wr, a1_mem, a1_memwr, a1_ill}, 4'b1100);
    chk("vld_bo_err", a1_err, 0);

    // execute back-pressure
    send(mk(RT, 8, 9, 10), s);
    if_inst = mk(RT, 11, 12, 13); if_valid = 1'b1; ex_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("bp_stall", id_stall, 1);
      chk("bp_hold", {id_valid, id_rD}, {1'b1, 5'd8});
      @(posedge clk); #1;
    end
    ex_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {id_valid, id_rD}, {1'b1, 5'd11});

    // flush beats a hazard; the killed writer no longer blocks r5 readers
    send(mk(RT, 5, 0, 0), s);
    if_inst = mk(RT, 14, 5, 0); if_valid = 1'b1; ex_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", id_stall, 0);
    @(posedge clk); #1;
    chk("flush_bubble", id_valid, 0);
    flush = 1'b0;
    send(mk(RT, 15, 5, 0), s);
    chk("post_flush_stalls", s, 0);
    chk("post_flush_rD", id_rD, 15);

    // error counter saturation
    if_inst = mk(6'b000000, 0, 0, 0); if_valid = 1'b1; ex_ready = 1'b1;
    repeat (300) @(posedge clk);
    #1 if_valid = 1'b0;
    chk("err_saturate", err_cnt, 255);

    // asynchronous reset mid-stream
    send(mk(RT, 3, 1, 2), s);
    chk("pre_reset_valid", id_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", id_valid, 0);
    chk("mid_rst_enables", {id_wrEn, id_memEn, id_memwrEn, id_bez, id_bnez, id_illegal}, 0);
    chk("mid_rst_fields", {id_rD, id_rA, id_rB, id_ppp, id_WW, id_opcode, id_imm}, 0);
    chk("mid_rst_err", err_cnt, 0);
    chk("mid_rst_stall", id_stall, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
